// File: rtl/axis_capture_mem.sv
// axis_capture_mem: multi-lane AXI-stream capture buffer (circular RAM, continuous or triggered one-shot).
// Latency: count/wr_ptr/frozen update 1 cycle after an accepted beat; rd_valid/rd_data READ_LATENCY cycles after rd_en.
// Backpressure: none; s_axis_tready is low only while rst is high. Beats in IDLE/FROZEN are accepted and dropped.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_tvalid/tready/tdata/tlast
//                            input stream, NUM_CHANNELS lanes of DATA_WIDTH, lane 0 in the LSBs
//   mode, arm, trig, post_count
//                            0 = rolling window, 1 = triggered; arm starts a capture, trig qualifies
//                            a beat, post_count sets how many beats follow the trigger beat
//   frozen, count, trig_index
//                            capture status; trig_index is the read index of the trigger beat
//   rd_en, rd_addr, rd_chan  read request, index relative to the oldest stored beat, lane select
//   rd_valid, rd_data        read response
module axis_capture_mem #(
  parameter int    NUM_CHANNELS   = 4,
  parameter int    DATA_WIDTH     = 16,
  parameter int    MEMORY_DEPTH   = 32,
  parameter string MEMORY_TYPE    = "distributed",
  parameter int    READ_LATENCY   = 1,
  parameter bit    CLEAR_ON_TLAST = 1'b1,
  localparam int   AW             = $clog2(MEMORY_DEPTH),
  localparam int   CW             = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                             s_axis_tlast,
  input  logic                             mode,
  input  logic                             arm,
  input  logic                             trig,
  input  logic [AW-1:0]                    post_count,
  output logic                             frozen,
  output logic [AW:0]                      count,
  output logic [AW-1:0]                    trig_index,
  input  logic                             rd_en,
  input  logic [AW-1:0]                    rd_addr,
  input  logic [CW-1:0]                    rd_chan,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data
);

  // Elaboration-time parameter legality checks.
  if ((MEMORY_DEPTH < 4) || ((MEMORY_DEPTH & (MEMORY_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axis_capture_mem: MEMORY_DEPTH must be a power of two >= 4");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("axis_capture_mem: READ_LATENCY must be 1 or 2");
  end
  if (!((MEMORY_TYPE == "distributed") || (MEMORY_TYPE == "block") || (MEMORY_TYPE == "auto"))) begin : g_bad_type
    $error("axis_capture_mem: MEMORY_TYPE must be distributed, block or auto");
  end

  localparam int             BW      = NUM_CHANNELS * DATA_WIDTH;
  localparam logic [AW:0]    DEPTH_C = MEMORY_DEPTH[AW:0];
  localparam logic [AW:0]    CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]  AW_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_RUN,
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_FROZEN
  } state_t;

  // Capture control state
  state_t          state_q,      state_d;
  logic [AW-1:0]   wr_ptr_q,     wr_ptr_d;
  logic [AW:0]     count_q,      count_d;
  logic            sof_q,        sof_d;
  logic [AW-1:0]   post_rem_q,   post_rem_d;
  logic [AW-1:0]   post_len_q,   post_len_d;
  logic            frozen_q,     frozen_d;
  logic [AW-1:0]   trig_index_q, trig_index_d;

  // Read pipeline: stage 0 is the first register after the RAM read.
  logic [READ_LATENCY-1:0]                 rd_vld_q,  rd_vld_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] rd_pipe_q, rd_pipe_d;

  // Storage: asynchronous read feeding a register maps straight onto LUT RAM;
  // for block RAM the tool absorbs the stage-0 register into the primitive.
  logic [BW-1:0]   mem_q [MEMORY_DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;

  logic            beat;
  logic            freeze;
  logic [AW:0]     count_inc;
  logic [AW-1:0]   rd_phys;
  logic [BW-1:0]   rd_word;
  logic [DATA_WIDTH-1:0] rd_lane;

  assign s_axis_tready = ~rst;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign count_inc     = (count_q == DEPTH_C) ? count_q : (count_q + CNT_ONE);

  // ---------------------------------------------------------------------------
  // Capture control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    sof_d        = sof_q;
    post_rem_d   = post_rem_q;
    post_len_d   = post_len_q;
    frozen_d     = frozen_q;
    trig_index_d = trig_index_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q;
    freeze       = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (beat) begin
          mem_we = 1'b1;
          if (CLEAR_ON_TLAST && sof_q) begin
            // First beat of a new frame restarts the window at address 0, so the
            // previous frame stays intact until this point.
            mem_waddr = '0;
            wr_ptr_d  = AW_ONE;
            count_d   = CNT_ONE;
          end else begin
            wr_ptr_d  = wr_ptr_q + AW_ONE;
            count_d   = count_inc;
          end
          sof_d = CLEAR_ON_TLAST && s_axis_tlast;
        end
      end
      ST_ARMED: begin
        if (beat) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW_ONE;
          count_d  = count_inc;
          if (trig) begin
            if (post_rem_q == '0) begin
              freeze = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
      end
      ST_POST: begin
        if (beat) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + AW_ONE;
          count_d    = count_inc;
          post_rem_d = post_rem_q - AW_ONE;
          if (post_rem_q == AW_ONE) begin
            freeze = 1'b1;
          end
        end
      end
      default: begin
        // IDLE / FROZEN: accepted beats are dropped.
      end
    endcase

    // Trigger position is derived from the final count: the trigger beat sits
    // post_len beats before the newest stored beat.
    if (freeze) begin
      state_d      = ST_FROZEN;
      frozen_d     = 1'b1;
      trig_index_d = count_d[AW-1:0] - AW_ONE - post_len_q;
    end

    // arm restarts the capture and takes priority over anything above; a beat
    // arriving in the same cycle becomes the first beat of the new capture.
    if (mode && (state_q != ST_RUN) && arm) begin
      state_d    = ST_ARMED;
      frozen_d   = 1'b0;
      post_rem_d = post_count;
      post_len_d = post_count;
      mem_we     = beat;
      mem_waddr  = '0;
      wr_ptr_d   = beat ? AW_ONE : '0;
      count_d    = beat ? CNT_ONE : '0;
    end

    // Mode switches override the state machine.
    if (!mode) begin
      if (state_q != ST_RUN) begin
        state_d  = ST_RUN;
        frozen_d = 1'b0;
      end
    end else if (state_q == ST_RUN) begin
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_phys = wr_ptr_q - count_q[AW-1:0] + rd_addr;
    rd_word = mem_q[rd_phys];
    rd_lane = '0;
    // Indices past the stored data or past the last lane read as zero.
    if ({1'b0, rd_addr} < count_q) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (rd_chan == c[CW-1:0]) begin
          rd_lane = rd_word[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    rd_vld_d     = rd_vld_q;
    rd_pipe_d    = rd_pipe_q;
    rd_vld_d[0]  = rd_en;
    rd_pipe_d[0] = rd_lane;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  assign rd_valid   = rd_vld_q[READ_LATENCY-1];
  assign rd_data    = rd_pipe_q[READ_LATENCY-1];
  assign frozen     = frozen_q;
  assign count      = count_q;
  assign trig_index = trig_index_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= mode ? ST_IDLE : ST_RUN;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      sof_q        <= 1'b0;
      post_rem_q   <= '0;
      post_len_q   <= '0;
      frozen_q     <= 1'b0;
      trig_index_q <= '0;
      rd_vld_q     <= '0;
      rd_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      sof_q        <= sof_d;
      post_rem_q   <= post_rem_d;
      post_len_q   <= post_len_d;
      frozen_q     <= frozen_d;
      trig_index_q <= trig_index_d;
      rd_vld_q     <= rd_vld_d;
      rd_pipe_q    <= rd_pipe_d;
    end
  end

  // RAM write; the read above samples the pre-edge contents (read-first).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= s_axis_tdata;
    end
  end

endmodule

// File: doc/axis_capture_mem.md
# axis_capture_mem

Multi-channel AXI-stream capture buffer. It stores NUM_CHANNELS parallel lanes per beat in a circular RAM and supports two modes: continuous (rolling window) and triggered one-shot with a programmable post-trigger length. A read port presents samples indexed from the oldest stored beat. It sits after the sample pipeline and feeds register-mapped debug and readout logic.

## Interface
- NUM_CHANNELS, 4, lanes packed in s_axis_tdata; lane 0 in the LSBs.
- DATA_WIDTH, 16, bits per lane.
- MEMORY_DEPTH, 32, beats stored. Must be a power of two, ≥ 4.
- MEMORY_TYPE, "distributed", RAM primitive selection.
- READ_LATENCY, 1, read pipeline depth. Legal values are 1 or 2.
- CLEAR_ON_TLAST, 1, restart the buffer at frame boundaries in continuous mode.
- Derived: AW = log2(MEMORY_DEPTH); CW = max(1, log2(NUM_CHANNELS)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  0 while rst is high, otherwise 1.
- s_axis_tdata  in  NUM_CHANNELS*DATA_WIDTH  packed lanes.
- s_axis_tlast  in  1  end of frame.
- mode  in  1  0 = continuous, 1 = triggered.
- arm  in  1  pulse; start a triggered capture.
- trig  in  1  trigger qualifier, sampled with an accepted beat.
- post_count  in  AW  beats to store after the trigger beat; sampled on arm.
- frozen  out  1  triggered capture complete.
- count  out  AW+1  valid beats stored, 0..MEMORY_DEPTH.
- trig_index  out  AW  read index of the trigger beat; valid while frozen.
- rd_en  in  1  read request.
- rd_addr  in  AW  index relative to the oldest stored beat.
- rd_chan  in  CW  lane select.
- rd_valid  out  1  read data valid.
- rd_data  out  DATA_WIDTH  read data.

## Operation
- Accepted beat = s_axis_tvalid & s_axis_tready. A write occurs at wr_ptr on an accepted beat only in states RUN, ARMED and POST. wr_ptr then increments, wrapping MEMORY_DEPTH-1 → 0. count increments and saturates at MEMORY_DEPTH.
- States are RUN, IDLE, ARMED, POST and FROZEN.
- Reset state: RUN if mode=0, IDLE if mode=1. On reset wr_ptr=0 and count=0.
- mode change: mode=0 forces RUN from any state. mode=1 while in RUN forces IDLE.
- Continuous mode (RUN) with CLEAR_ON_TLAST=1:
  - An accepted tlast beat is written normally and sets an internal sof flag.
  - The next accepted beat is written at address 0, sets count=1, and clears sof.
  - The completed frame therefore stays readable until the next frame starts.
- CLEAR_ON_TLAST=0: tlast is ignored.
- arm (any triggered state):
  - Goes to ARMED, sets wr_ptr=0, count=0, frozen=0.
  - Latches post_count into post_rem.
  - arm in RUN is ignored.
- ARMED: an accepted beat with trig=1 is written.
  - post_rem=0 → FROZEN.
  - Otherwise → POST.
  - trig without an accepted beat is ignored.
- POST: each accepted beat is written and decrements post_rem. The beat that brings post_rem from 1 to 0 → FROZEN. trig is ignored.
- IDLE and FROZEN: beats are accepted and discarded; memory and count do not change.
- trig_index = count - 1 - post_count_latched, computed on entry to FROZEN and held there.
- Read path:
  - Physical address = (wr_ptr - count + rd_addr) mod MEMORY_DEPTH, sampled on the rd_en cycle.
  - Lane rd_chan is selected.
  - rd_addr ≥ count, or rd_chan ≥ NUM_CHANNELS, returns zero with rd_valid still asserted.
- A read and a write to the same address in the same cycle return the old contents (read-first).

## Timing
- Reset values: s_axis_tready=0, frozen=0, count=0, trig_index=0, rd_valid=0, rd_data=0.
- Write latency: count and wr_ptr reflect an accepted beat on the next cycle. frozen rises the cycle after the final beat.
- rd_valid and rd_data follow rd_en by exactly READ_LATENCY cycles. Back-to-back reads are fully pipelined.
- rst asserted mid-capture: the next cycle equals the reset state. In-flight reads are flushed (rd_valid=0).
- arm coincident with an accepted trig beat: arm wins. The beat is written as the first beat of the new capture, and trig is ignored.
- Wrap-around: once count=MEMORY_DEPTH, every write overwrites the oldest beat. rd_addr=0 always returns the oldest surviving beat.

## Test plan
- Bench configuration for all scenarios: NUM_CHANNELS=2, DATA_WIDTH=8, MEMORY_DEPTH=8.
- Continuous: send beats with lane0=1..11 and lane1=lane0+100. Expected: count=8; reads of rd_addr 0..7 on lane 0 return 4..11; on lane 1 they return 104..111.
- CLEAR_ON_TLAST: send 3 beats, tlast on the 3rd. Expected: count=3 and frame readable. Then send beat value 50. Expected: count=1, rd_addr 0 returns 50.
- Triggered: arm with post_count=2, then send 1..20 with trig on value 10. Expected: frozen after beat 12; count=8; reads 0..7 return 5..12; trig_index=5; beats 13..20 discarded.
- Triggered, zero post length: post_count=0, trig on the first beat after arm. Expected: frozen=1, count=1, trig_index=0. Then re-arm. Expected: frozen=0, count=0.
- Read edge cases:
  - With count=3: rd_addr=5 → rd_data=0 with rd_valid=1.
  - READ_LATENCY=2: rd_valid arrives 2 cycles after rd_en.
  - A read of the physical address being written returns the old value.
- Reset mid-POST: expected s_axis_tready=0 for the rst cycle, then state IDLE, count=0, frozen=0, rd_valid=0.
